fft_frame_sched: RTL
====================

// Module: fft_frame_sched
// PURPOSE
//  Frame-level scheduler for the 1024-point FFT engine. Tracks a ping-pong input
//  sample buffer, pulses the address generator's start, and waits for its end-of-frame
//  (vga_start) pulse. Then grants the result RAM port to the display reader and
//  enforces a watchdog on the FFT. Sits between the sample writer, addr_gen_unit and the VGA path.
// PARAMETERS
//  N_LOG2       10     log2 FFT points; only used for documentation/asserts
//  TIMEOUT_CYC  16384  max cycles from fft_start_o to vga_start_i before abort
//  FRAME_CNT_W  16     width of completed-frame counter
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            synchronous, active-low reset
//  enable_i     in   1            allow new frames to start
//  clr_status_i in   1            clear sticky overrun_o/timeout_o
//  fill_done_i  in   1            1-cycle pulse: sample writer filled half capt_sel_o
//  capt_sel_o   out  1            half the sample writer fills
//  fft_sel_o    out  1            half the FFT loads from
//  fft_start_o  out  1            1-cycle start pulse to address generator
//  fft_rst_n_o  out  1            sync active-low reset to address generator
//  vga_start_i  in   1            1-cycle pulse: FFT output phase finished
//  disp_req_i   in   1            display reader requests result RAM (level)
//  disp_gnt_o   out  1            result RAM granted to display reader
//  fft_busy_o   out  1            FFT owns input/result RAMs
//  frame_cnt_o  out  FRAME_CNT_W  completed frames, wraps
//  overrun_o    out  1            sticky: fill arrived while other half still pending
//  timeout_o    out  1            sticky: watchdog fired
//  state_o      out  3            FSM state encoding, debug
// BEHAVIOUR
//  Reset values: all outputs 0 except fft_rst_n_o=0 during reset, 1 first cycle after.
//   State IDLE; pending flag 0; watchdog 0.
//  Ping-pong: on fill_done_i with pending=0 -> pending<=1, pend_sel<=capt_sel_o,
//   capt_sel_o toggles. With pending=1 -> overrun_o<=1; capt_sel_o unchanged, pending kept.
//   fill_done_i same cycle as pending clear (START) -> pending stays 1, no overrun.
//  FSM (all outputs registered):
//   IDLE    : enable_i -> ARM.
//   ARM     : enable_i=0 -> IDLE; pending=1 -> START.
//   START   : fft_start_o=1 (exactly 1 cycle); fft_sel_o<=pend_sel; pending<=0 -> RUN.
//   RUN     : fft_busy_o=1; watchdog counts. vga_start_i -> frame_cnt_o+1, DISPLAY.
//             Watchdog reaches TIMEOUT_CYC-1 -> timeout_o<=1, ABORT.
//   DISPLAY : disp_gnt_o=disp_req_i (registered, 1-cycle latency). disp_req_i=0 -> ARM.
//   ABORT   : fft_rst_n_o=0 for exactly 2 cycles, pending<=0 -> IDLE.
//  disp_req_i raised during START/RUN/ABORT: no grant until DISPLAY.
//  New frame never starts while display holds grant. enable_i drop mid-frame: frame completes,
//   stops at ARM->IDLE. fft_sel_o constant from START to next START.
//  vga_start_i outside RUN ignored. clr_status_i clears sticky bits; a same-cycle set wins.
//  frame_cnt_o wraps 2^FRAME_CNT_W-1 -> 0. Watchdog clears on START.
//  rst_n low in any state -> reset values next edge, including fft_rst_n_o=0.
// STRUCTURE
//  Package fft_pkg: N_LOG2, TIMEOUT_CYC default, state localparams
//   (IDLE=0, ARM=1, START=2, RUN=3, DISPLAY=4, ABORT=5).
//  Sub-module pingpong_tracker: capt_sel/pending/pend_sel/overrun logic, clear input.
//  FSM, watchdog, frame counter in top.
// TESTING
//  Reset then enable_i=1, fill_done_i pulse -> capt_sel_o 0->1; fft_sel_o=0;
//   fft_start_o high 1 cycle, 2 cycles after the pulse.
//  Model addr gen: vga_start_i 2600 cycles after start -> frame_cnt_o=1;
//   disp_req_i=1 -> disp_gnt_o=1 next cycle; drop -> grant 0, state ARM.
//  Two fill_done_i pulses during RUN -> second sets overrun_o=1; capt_sel_o toggles once.
//   clr_status_i clears it.
//  vga_start_i withheld, TIMEOUT_CYC=64 -> timeout_o=1 at start+64;
//   fft_rst_n_o low 2 cycles; state IDLE; pending 0.
//  fill_done_i same cycle as START -> no overrun; next START after DISPLAY uses the new half.
//  rst_n low mid-RUN -> all outputs reset values next edge; frame_cnt_o=0.
//   FRAME_CNT_W=2: 4 frames -> wraps to 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT frame scheduler.
// Frame-level timing lives in the top; this package only names things.
package fft_pkg;

  localparam int N_LOG2          = 10;
  localparam int FFT_POINTS      = 1 << N_LOG2;
  localparam int TIMEOUT_CYC_DEF = 16384;
  localparam int FRAME_CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_START   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DISPLAY = 3'd4,
    ST_ABORT   = 3'd5
  } sched_state_t;

  // Watchdog only has to hold values up to cyc-1.
  function automatic int wd_width(input int cyc);
    return (cyc <= 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/fft_frame_sched_if.sv
// Scheduler-facing bundle: sample writer, address generator and display reader signals.
// master = scheduler side, slave = surrounding datapath.
interface fft_frame_sched_if #(
  parameter int FRAME_CNT_W = 16
);
  import fft_pkg::*;

  logic                   enable_i;
  logic                   clr_status_i;
  logic                   fill_done_i;
  logic                   capt_sel_o;
  logic                   fft_sel_o;
  logic                   fft_start_o;
  logic                   fft_rst_n_o;
  logic                   vga_start_i;
  logic                   disp_req_i;
  logic                   disp_gnt_o;
  logic                   fft_busy_o;
  logic [FRAME_CNT_W-1:0] frame_cnt_o;
  logic                   overrun_o;
  logic                   timeout_o;
  logic [$bits(sched_state_t)-1:0] state_o;

  modport master (
    input  enable_i, clr_status_i, fill_done_i, vga_start_i, disp_req_i,
    output capt_sel_o, fft_sel_o, fft_start_o, fft_rst_n_o, disp_gnt_o,
           fft_busy_o, frame_cnt_o, overrun_o, timeout_o, state_o
  );

  modport slave (
    output enable_i, clr_status_i, fill_done_i, vga_start_i, disp_req_i,
    input  capt_sel_o, fft_sel_o, fft_start_o, fft_rst_n_o, disp_gnt_o,
           fft_busy_o, frame_cnt_o, overrun_o, timeout_o, state_o
  );
endinterface

// File: rtl/fft_frame_sched_pingpong.sv
// Ping-pong input buffer bookkeeping: which half is being filled, which is waiting for the FFT.
// All state registered; a fill that lands on the same edge as the FFT taking the pending half is accepted.
module pingpong_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic fill_done,
  input  logic clear_pending,
  input  logic clr_status,
  output logic capt_sel,
  output logic pend_sel,
  output logic pending,
  output logic overrun
);

  logic accept;
  logic overrun_set;

  always_comb begin
    accept      = fill_done && (!pending || clear_pending);
    overrun_set = fill_done && pending && !clear_pending;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      capt_sel <= 1'b0;
      pend_sel <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (accept) begin
        pending  <= 1'b1;
        pend_sel <= capt_sel;
        capt_sel <= ~capt_sel;
      end else if (clear_pending) begin
        pending  <= 1'b0;
      end
      // A new overrun in the same cycle as a clear request stays visible.
      if (overrun_set)
        overrun <= 1'b1;
      else if (clr_status)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the FFT engine: ping-pong hand-off, start pulse, watchdog, display grant.
// Outputs registered, one cycle behind the FSM decision; display grant follows disp_req_i by one cycle.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  fft_frame_sched_if.master  bus
);

  localparam int              WD_W    = wd_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  sched_state_t           state, state_nxt;
  logic [WD_W-1:0]        wd;
  logic                   abort_2nd;
  logic                   clear_pending;
  logic                   timeout_set;
  logic                   capt_sel, pend_sel, pending, overrun;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   timeout;
  logic                   fft_start, fft_sel, fft_rst_n, fft_busy, disp_gnt;

  pingpong_tracker u_pingpong (
    .clk           (clk),
    .rst_n         (rst_n),
    .fill_done     (bus.fill_done_i),
    .clear_pending (clear_pending),
    .clr_status    (bus.clr_status_i),
    .capt_sel      (capt_sel),
    .pend_sel      (pend_sel),
    .pending       (pending),
    .overrun       (overrun)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    clear_pending = 1'b0;
    timeout_set   = 1'b0;
    case (state)
      ST_IDLE:
        if (bus.enable_i) state_nxt = ST_ARM;
      ST_ARM:
        if (!bus.enable_i) state_nxt = ST_IDLE;
        else if (pending)  state_nxt = ST_START;
      ST_START: begin
        state_nxt     = ST_RUN;
        clear_pending = 1'b1;
      end
      ST_RUN:
        // End-of-frame wins over a watchdog expiring in the same cycle.
        if (bus.vga_start_i) begin
          state_nxt = ST_DISPLAY;
        end else if (wd == WD_LAST) begin
          state_nxt   = ST_ABORT;
          timeout_set = 1'b1;
        end
      ST_DISPLAY:
        if (!bus.disp_req_i) state_nxt = ST_ARM;
      ST_ABORT:
        if (abort_2nd) begin
          state_nxt     = ST_IDLE;
          clear_pending = 1'b1;
        end
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd        <= '0;
      abort_2nd <= 1'b0;
      frame_cnt <= '0;
      timeout   <= 1'b0;
      fft_start <= 1'b0;
      fft_sel   <= 1'b0;
      fft_rst_n <= 1'b0;
      fft_busy  <= 1'b0;
      disp_gnt  <= 1'b0;
    end else begin
      fft_start <= (state_nxt == ST_START);
      fft_busy  <= (state_nxt == ST_RUN);
      fft_rst_n <= (state_nxt != ST_ABORT);
      disp_gnt  <= (state_nxt == ST_DISPLAY) && bus.disp_req_i;
      abort_2nd <= (state == ST_ABORT) && !abort_2nd;

      // Latch the half alongside the start pulse so the engine sees both together.
      if (state == ST_ARM && state_nxt == ST_START)
        fft_sel <= pend_sel;

      if (state_nxt == ST_START)
        wd <= '0;
      else if (state == ST_START || state == ST_RUN)
        wd <= wd + WD_W'(1);

      if (state == ST_RUN && bus.vga_start_i)
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);

      if (timeout_set)
        timeout <= 1'b1;
      else if (bus.clr_status_i)
        timeout <= 1'b0;
    end
  end

  assign bus.capt_sel_o  = capt_sel;
  assign bus.fft_sel_o   = fft_sel;
  assign bus.fft_start_o = fft_start;
  assign bus.fft_rst_n_o = fft_rst_n;
  assign bus.disp_gnt_o  = disp_gnt;
  assign bus.fft_busy_o  = fft_busy;
  assign bus.frame_cnt_o = frame_cnt;
  assign bus.overrun_o   = overrun;
  assign bus.timeout_o   = timeout;
  assign bus.state_o     = state;

endmodule
